fuzzy_mmio_host: RTL and testbench
==================================

// Module: fuzzy_mmio_host
// PURPOSE
//  Bus initiator for the fuzzy coprocessor MMIO slave port (cs/rd/wr/addr/wdata/rdata, status_busy/status_valid).
//  Forwards a configuration write stream (MF points, g-table, alpha/k_dt/d_max, mode bits) to the slave.
//  For each (T,dT) sample: writes T and dT, pulses START, waits for status_valid, reads G_out, returns it on a result handshake.
//  Sits between the system-side controller/testbench and the coprocessor top.
// PARAMETERS
//  ADDR_CTRL   8'h00  control register address (mode bits + START strobe)
//  ADDR_T      8'h01  T_reg address
//  ADDR_DT     8'h02  dT_reg address
//  ADDR_GOUT   8'h03  G_out read address
//  START_MASK  8'h01  bit OR-ed into the control shadow on the START write
//  TIMEOUT_CYC 256    max cycles spent in WAIT before abort (>=4)
// PORTS
//  clk          in   1  clock
//  rst_n        in   1  asynchronous, active-low reset
//  cfg_valid    in   1  config write request
//  cfg_ready    out  1  config write accepted when cfg_valid&&cfg_ready
//  cfg_addr     in   8  config register address
//  cfg_data     in   8  config register data
//  smp_valid    in   1  sample request
//  smp_ready    out  1  sample accepted when smp_valid&&smp_ready
//  smp_T        in   8  temperature sample
//  smp_dT       in   8  dT sample (ignored by slave when dt_mode=1)
//  res_valid    out  1  result available
//  res_ready    in   1  result consumed when res_valid&&res_ready
//  res_G        out  8  G_out read from slave (0..100); 0 on timeout
//  res_timeout  out  1  result aborted by timeout
//  cs,rd,wr     out  1  MMIO strobes, one-cycle, registered
//  addr         out  8  MMIO address
//  wdata        out  8  MMIO write data
//  rdata        in   8  MMIO read data, valid the cycle after rd
//  status_busy  in   1  slave busy
//  status_valid in   1  slave result strobe (one-cycle pulse)
//  n_timeouts   out  8  saturating timeout counter
// BEHAVIOUR
//  Reset: all outputs 0 except cfg_ready=1, smp_ready=1; state IDLE; ctrl shadow=0; counters=0.
//  Reset mid-transaction aborts immediately; no partial result is ever emitted.
//  Bus outputs are registered from state; cs=0 => rd=wr=0, addr/wdata=0. Never rd&&wr.
//  FSM: IDLE, CFG, WR_T, WR_DT, WR_GO, WAIT, RD, CAP, RES.
//  - IDLE: cfg_ready=smp_ready=1. cfg_valid has priority; if both are high, only cfg is accepted (smp_ready is forced low that cycle).
//  - CFG: one write cycle (cs=wr=1, addr=cfg_addr, wdata=cfg_data) -> IDLE. cfg_addr==ADDR_CTRL also loads the ctrl shadow with cfg_data&~START_MASK.
//  - Sample accept latches T/dT; WR_T, WR_DT and WR_GO each drive one write cycle; WR_GO drives wdata=shadow|START_MASK at ADDR_CTRL.
//  - WAIT: watches status_valid each cycle; on 1 -> RD. The wait counter counts from 0; at TIMEOUT_CYC-1 -> RES with res_timeout=1, res_G=0, n_timeouts+1 (saturating at 255).
//  - RD: cs=rd=1, addr=ADDR_GOUT -> CAP. CAP: res_G<=rdata -> RES.
//  - RES: res_valid=1 and holds res_G/res_timeout stable until res_ready; exits to IDLE on the handshake cycle.
//  Latency: the accept edge puts the T write on the bus the next cycle. The START write is 3rd bus cycle after accept.
//  res_valid rises 3 cycles after the cycle in which status_valid=1 is sampled (RD, CAP, then RES).
//  A status_valid pulse outside WAIT is ignored. status_busy is informational only and does not alter flow.
//  Only one transaction is in flight; both ready outputs are 0 outside IDLE.
// TESTING
//  1) cfg_valid addr=8'h10 data=8'h20 -> one cycle cs=wr=1 addr=10 wdata=20, cfg_ready low 1 cycle, no rd.
//  2) cfg ctrl=8'h03 then sample T=8'h40 dT=8'h05; slave valid 2 cycles after START; rdata=8'd57
//     -> bus: wr 01=40, wr 02=05, wr 00=03, rd 03; res_G=57, res_timeout=0.
//  3) cfg_valid&&smp_valid same cycle -> cfg write first, then sample sequence; no lost request.
//  4) Slave never asserts status_valid, TIMEOUT_CYC=16 -> res_valid with res_timeout=1, res_G=0, n_timeouts=1.
//  5) res_ready held low 10 cycles -> res_valid/res_G stable, smp_ready=0 throughout; IDLE after handshake.
//  6) rst_n asserted during WAIT -> all strobes 0, res_valid=0, ready outputs 1; a fresh sample afterwards completes normally.

Source files
------------

// File: rtl/fuzzy_mmio_host.sv
// MMIO bus initiator for the fuzzy coprocessor: forwards config writes, runs
// one T/dT sample per transaction (write, START, wait, read G_out) and returns the result.
module fuzzy_mmio_host #(
    parameter logic [7:0] ADDR_CTRL   = 8'h00,
    parameter logic [7:0] ADDR_T      = 8'h01,
    parameter logic [7:0] ADDR_DT     = 8'h02,
    parameter logic [7:0] ADDR_GOUT   = 8'h03,
    parameter logic [7:0] START_MASK  = 8'h01,
    parameter int         TIMEOUT_CYC = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic       smp_valid,
    output logic       smp_ready,
    input  logic [7:0] smp_T,
    input  logic [7:0] smp_dT,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_G,
    output logic       res_timeout,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    input  logic [7:0] rdata,
    input  logic       status_busy,
    input  logic       status_valid,
    output logic [7:0] n_timeouts
);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [3:0] {
        IDLE, CFG, WR_T, WR_DT, WR_GO, WAIT, RD, CAP, RES
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      shadow_q, shadow_d;
    logic [7:0]      t_q, t_d, dt_q, dt_d;
    logic [7:0]      res_g_q, res_g_d;
    logic            res_to_q, res_to_d;
    logic [7:0]      nto_q, nto_d;
    logic            cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
    logic [7:0]      addr_q, addr_d, wdata_q, wdata_d;

    // Busy is informational only; the flow is driven purely by status_valid.
    wire unused_busy = status_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            t_q      <= '0;
            dt_q     <= '0;
            res_g_q  <= '0;
            res_to_q <= 1'b0;
            nto_q    <= '0;
            cs_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            t_q      <= t_d;
            dt_q     <= dt_d;
            res_g_q  <= res_g_d;
            res_to_q <= res_to_d;
            nto_q    <= nto_d;
            cs_q     <= cs_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Bus strobes are computed for the state being entered, so each bus
    // cycle lines up with the cycle spent in CFG/WR_*/RD.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        t_d      = t_q;
        dt_d     = dt_q;
        res_g_d  = res_g_q;
        res_to_d = res_to_q;
        nto_d    = nto_q;
        cs_d     = 1'b0;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    state_d = CFG;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = cfg_addr;
                    wdata_d = cfg_data;
                    if (cfg_addr == ADDR_CTRL) shadow_d = cfg_data & ~START_MASK;
                end else if (smp_valid) begin
                    state_d = WR_T;
                    t_d     = smp_T;
                    dt_d    = smp_dT;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = ADDR_T;
                    wdata_d = smp_T;
                end
            end
            CFG: state_d = IDLE;
            WR_T: begin
                state_d = WR_DT;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = ADDR_DT;
                wdata_d = dt_q;
            end
            WR_DT: begin
                state_d = WR_GO;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = ADDR_CTRL;
                wdata_d = shadow_q | START_MASK;
            end
            WR_GO: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (status_valid) begin
                    state_d = RD;
                    cs_d    = 1'b1;
                    rd_d    = 1'b1;
                    addr_d  = ADDR_GOUT;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d  = RES;
                    res_g_d  = '0;
                    res_to_d = 1'b1;
                    if (nto_q != 8'hFF) nto_d = nto_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD: state_d = CAP;
            CAP: begin
                state_d  = RES;
                res_g_d  = rdata;
                res_to_d = 1'b0;
            end
            RES: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cfg_ready   = (state_q == IDLE);
    assign smp_ready   = (state_q == IDLE) && !cfg_valid;
    assign res_valid   = (state_q == RES);
    assign res_G       = res_g_q;
    assign res_timeout = res_to_q;
    assign n_timeouts  = nto_q;
    assign cs          = cs_q;
    assign rd          = rd_q;
    assign wr          = wr_q;
    assign addr        = addr_q;
    assign wdata       = wdata_q;
endmodule

// File: tb/tb_fuzzy_mmio_host.sv
// Scoreboard bench for fuzzy_mmio_host: a behavioural slave, a transaction-level
// reference pushing expected bus ops and results, and decoupled monitors.
module tb_fuzzy_mmio_host;
    localparam int TO = 16;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cfg_valid = 0, cfg_ready, smp_valid = 0, smp_ready;
    logic [7:0] cfg_addr = 0, cfg_data = 0, smp_T = 0, smp_dT = 0;
    logic       res_valid, res_ready = 0, res_timeout;
    logic [7:0] res_G, addr, wdata, n_timeouts;
    logic       cs, rd, wr;
    logic [7:0] rdata;
    logic       status_valid, status_busy;

    typedef struct { logic rd; logic [7:0] addr; logic [7:0] data; } bus_op_t;
    typedef struct { logic [7:0] g; logic to; } res_t;
    bus_op_t qbus[$];
    res_t    qres[$];

    int checks = 0, errors = 0;
    int slave_delay = 0;
    logic [7:0] slave_g = 0;
    logic [7:0] m_shadow = 0;
    int m_nto = 0;
    int rr_hold = 0;

    fuzzy_mmio_host #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_T(smp_T), .smp_dT(smp_dT),
        .res_valid(res_valid), .res_ready(res_ready), .res_G(res_G), .res_timeout(res_timeout),
        .cs(cs), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
        .status_busy(status_busy), .status_valid(status_valid), .n_timeouts(n_timeouts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: status_valid pulses in the slave_delay-th cycle after the START
    // write (0 = never); G_out is returned the cycle after rd.
    int scnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= 0; status_valid <= 0; status_busy <= 0; rdata <= 0;
        end else begin
            status_valid <= 0;
            rdata <= rd ? slave_g : 8'h00;
            if (cs && wr && addr == 8'h00 && wdata[0]) begin
                status_busy <= 1;
                if (slave_delay == 1) begin status_valid <= 1; scnt <= 0; end
                else scnt <= (slave_delay == 0) ? 0 : slave_delay - 1;
            end else if (scnt > 0) begin
                scnt <= scnt - 1;
                if (scnt == 1) begin status_valid <= 1; status_busy <= 0; end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rr_hold > 0) begin
            res_ready = 0;
            if (res_valid) rr_hold--;
        end else res_ready = ($urandom_range(0, 2) != 0);
    end

    // Bus monitor
    always @(negedge clk) begin
        if (rst_n) begin
            chk("no_rd_and_wr", {31'd0, rd && wr}, 32'd0);
            if (!cs) chk("idle_bus", {rd, wr, addr, wdata}, 18'd0);
            else if (qbus.size() == 0) chk("unexpected_bus_op", {rd, wr, addr, wdata}, 32'hFFFFFFFF);
            else begin
                bus_op_t e;
                e = qbus.pop_front();
                chk("bus_op", {rd, wr, addr, wdata}, {e.rd, !e.rd, e.addr, e.data});
            end
        end
    end

    // Result monitor with hold-stability check
    logic       hold_p = 0, hold_to;
    logic [7:0] hold_g;
    always @(negedge clk) begin
        if (!rst_n) hold_p = 0;
        else begin
            if (hold_p) chk("res_hold", {res_valid, res_timeout, res_G}, {1'b1, hold_to, hold_g});
            if (res_valid) chk("ready_low_in_res", {cfg_ready, smp_ready}, 2'b00);
            if (res_valid && res_ready) begin
                if (qres.size() == 0) chk("unexpected_result", {res_timeout, res_G}, 32'hFFFFFFFF);
                else begin
                    res_t e;
                    e = qres.pop_front();
                    if (e.to && m_nto < 255) m_nto++;
                    chk("res_G", res_G, e.g);
                    chk("res_timeout", res_timeout, e.to);
                    chk("n_timeouts", n_timeouts, m_nto);
                end
            end
            hold_p = res_valid && !res_ready;
            hold_to = res_timeout;
            hold_g = res_G;
        end
    end

    task automatic issue(input bit dc, input bit ds, input logic [7:0] ca, input logic [7:0] cd,
                         input logic [7:0] t, input logic [7:0] dt, input int dly, input logic [7:0] g);
        bit acc_c, acc_s;
        @(posedge clk); #1;
        cfg_valid = dc; cfg_addr = ca; cfg_data = cd;
        smp_valid = ds; smp_T = t; smp_dT = dt;
        for (int n = 0; n < 400 && (cfg_valid || smp_valid); n++) begin
            @(negedge clk);
            acc_c = cfg_valid && cfg_ready;
            acc_s = smp_valid && smp_ready;
            if (acc_c) begin
                qbus.push_back('{1'b0, ca, cd});
                if (ca == 8'h00) m_shadow = cd & 8'hFE;
            end
            if (acc_s) begin
                slave_delay = dly; slave_g = g;
                qbus.push_back('{1'b0, 8'h01, t});
                qbus.push_back('{1'b0, 8'h02, dt});
                qbus.push_back('{1'b0, 8'h00, m_shadow | 8'h01});
                if (dly >= 1 && dly <= TO) begin
                    qbus.push_back('{1'b1, 8'h03, 8'h00});
                    qres.push_back('{g, 1'b0});
                end else qres.push_back('{8'h00, 1'b1});
            end
            @(posedge clk); #1;
            if (acc_c) cfg_valid = 0;
            if (acc_s) smp_valid = 0;
        end
        if (cfg_valid || smp_valid) begin
            chk("accept_timeout", {cfg_valid, smp_valid}, 0);
            cfg_valid = 0; smp_valid = 0;
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 600 && (qbus.size() != 0 || qres.size() != 0); n++) @(negedge clk);
        chk("drain", qbus.size() + qres.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_strobes"}, {cs, rd, wr, addr, wdata}, 0);
        chk({tag, "_res"}, {res_valid, res_timeout, res_G}, 0);
        chk({tag, "_ready"}, {cfg_ready, smp_ready}, 2'b11);
        chk({tag, "_nto"}, n_timeouts, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1;
        // 1) plain config write; cfg_ready low for exactly one cycle
        issue(1, 0, 8'h10, 8'h20, 0, 0, 0, 0);
        @(negedge clk); chk("cfg_ready_low", cfg_ready, 0);
        @(negedge clk); chk("cfg_ready_back", cfg_ready, 1);
        // 2) ctrl=03 then sample, valid 2 cycles after START, G=57
        issue(1, 0, 8'h00, 8'h03, 0, 0, 0, 0);
        issue(0, 1, 0, 0, 8'h40, 8'h05, 2, 8'd57);
        wait_idle();
        // 3) simultaneous cfg and sample
        issue(1, 1, 8'h11, 8'h5A, 8'h22, 8'h33, 5, 8'd42);
        wait_idle();
        // 4) slave never responds; then boundary delays TO and TO+1
        issue(0, 1, 0, 0, 8'h50, 8'h01, 0, 8'd9);
        issue(0, 1, 0, 0, 8'h51, 8'h02, TO, 8'd77);
        issue(0, 1, 0, 0, 8'h52, 8'h03, TO + 1, 8'd78);
        wait_idle();
        // 5) consumer stalls for 10 cycles
        rr_hold = 10;
        issue(0, 1, 0, 0, 8'h60, 8'h06, 3, 8'd99);
        wait_idle();
        // 6) reset during WAIT
        issue(0, 1, 0, 0, 8'h70, 8'h07, 0, 8'd1);
        repeat (8) @(negedge clk);
        rst_n = 0;
        qbus.delete(); qres.delete();
        m_nto = 0; m_shadow = 0;
        #1 chk_reset_outputs("mid_reset");
        @(negedge clk); rst_n = 1;
        issue(0, 1, 0, 0, 8'h71, 8'h08, 4, 8'd64);
        wait_idle();
        // randomized mix
        for (int i = 0; i < 60; i++) begin
            int k, d;
            k = $urandom_range(0, 2);
            d = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TO + 4);
            issue(k != 1, k != 0, ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(4, 255)),
                  8'($urandom), 8'($urandom), 8'($urandom), d, 8'($urandom_range(0, 100)));
        end
        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
